// File: rtl/issue_pkg.sv
// Shared types for the decode/issue boundary.
// Register indices, scoreboard vector and instruction bundle.
package issue_pkg;

  localparam int ISSUE_NUM_REGS = 32;
  localparam int REG_ADDR_W     = 5;
  localparam int XLEN           = 32;

  localparam logic [REG_ADDR_W-1:0] REGISTER_X0 = '0;

  typedef logic [ISSUE_NUM_REGS-1:0] scoreboard_t;

  typedef enum logic [2:0] {
    OP_ALU    = 3'd0,
    OP_LOAD   = 3'd1,
    OP_STORE  = 3'd2,
    OP_BRANCH = 3'd3,
    OP_JUMP   = 3'd4,
    OP_SYSTEM = 3'd5
  } op_class_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
  } reg_file_read_params_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] insn;
    op_class_e       op;
  } instr_packet;

  function automatic logic is_x0(input logic [REG_ADDR_W-1:0] idx);
    return idx == REGISTER_X0;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register.
// A same-cycle set beats any clear since its writer is younger.
module reg_scoreboard
  import issue_pkg::*;
#(
  parameter int NUM_REGS = ISSUE_NUM_REGS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_idx,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_idx,
  input  logic                  flush_clr_en,
  input  logic [REG_ADDR_W-1:0] flush_clr_idx,
  output logic [NUM_REGS-1:0]   busy
);

  localparam logic [NUM_REGS-1:0] ONE = NUM_REGS'(1);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;
  logic [NUM_REGS-1:0] w_fclr;
  logic [NUM_REGS-1:0] w_next;

  always_comb begin
    w_set  = '0;
    w_clr  = '0;
    w_fclr = '0;
    if (set_en && !is_x0(set_idx))
      w_set = ONE << set_idx;
    if (clr_en && !is_x0(clr_idx))
      w_clr = ONE << clr_idx;
    if (flush_clr_en && !is_x0(flush_clr_idx))
      w_fclr = ONE << flush_clr_idx;
    w_next = (r_busy & ~w_clr & ~w_fclr) | w_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_busy <= '0;
    else
      r_busy <= w_next;
  end

  assign busy = r_busy;

endmodule

// File: rtl/decode_issue_stage.sv
// Issue stage: holds one decoded instruction for execute and
// stalls decode on RAW/WAW hazards against pending writes.
module decode_issue_stage
  import issue_pkg::*;
#(
  parameter int NUM_REGS    = ISSUE_NUM_REGS,
  parameter int STALL_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  instr_packet             in_instr,
  input  reg_file_read_params_t   in_params,
  input  logic                    in_writes_rd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output instr_packet             out_instr,
  output reg_file_read_params_t   out_params,
  input  logic                    wb_valid,
  input  logic [REG_ADDR_W-1:0]   wb_rd,
  input  logic                    flush,
  output logic [NUM_REGS-1:0]     busy_mask,
  output logic [STALL_CNT_W-1:0]  stall_cnt
);

  logic                   r_valid;
  instr_packet            r_instr;
  reg_file_read_params_t  r_params;
  logic                   r_held_wr;
  logic [STALL_CNT_W-1:0] r_stall;

  logic [NUM_REGS-1:0]    w_busy;
  logic                   w_rs1_busy;
  logic                   w_rs2_busy;
  logic                   w_rd_busy;
  logic                   w_hazard;
  logic                   w_accept;
  logic                   w_sets_rd;
  logic                   w_flush_clr;

  // Hazards look only at the registered scoreboard: no wb bypass.
  always_comb begin
    w_rs1_busy = !is_x0(in_params.rs1) && w_busy[in_params.rs1];
    w_rs2_busy = !is_x0(in_params.rs2) && w_busy[in_params.rs2];
    w_rd_busy  = in_writes_rd && !is_x0(in_params.rd)
                 && w_busy[in_params.rd];
    w_hazard   = in_valid && (w_rs1_busy || w_rs2_busy || w_rd_busy);
  end

  assign in_ready    = !w_hazard && !flush && (!r_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_sets_rd   = in_writes_rd && !is_x0(in_params.rd);
  assign w_flush_clr = flush && r_valid && r_held_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_instr   <= '0;
      r_params  <= '0;
      r_held_wr <= 1'b0;
    end else if (flush) begin
      r_valid   <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_instr   <= in_instr;
      r_params  <= in_params;
      r_held_wr <= w_sets_rd;
    end else if (out_ready) begin
      r_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stall <= '0;
    else if (w_hazard && !flush && !(&r_stall))
      r_stall <= r_stall + 1'b1;
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_sb (
    .clk           (clk),
    .rst           (rst),
    .set_en        (w_accept && in_writes_rd),
    .set_idx       (in_params.rd),
    .clr_en        (wb_valid),
    .clr_idx       (wb_rd),
    .flush_clr_en  (w_flush_clr),
    .flush_clr_idx (r_params.rd),
    .busy          (w_busy)
  );

  assign out_valid  = r_valid;
  assign out_instr  = r_instr;
  assign out_params = r_params;
  assign busy_mask  = w_busy;
  assign stall_cnt  = r_stall;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed checks for the issue stage: hazards, hold, flush,
// set-wins scoreboard, stall saturation and async reset.
module tb_decode_issue_stage;
  import issue_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  instr_packet           in_instr;
  reg_file_read_params_t in_params;
  logic                  in_writes_rd;
  logic                  out_valid;
  logic                  out_ready;
  instr_packet           out_instr;
  reg_file_read_params_t out_params;
  logic                  wb_valid;
  logic [4:0]            wb_rd;
  logic                  flush;
  logic [31:0]           busy_mask;
  logic [15:0]           stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decode_issue_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_params    (in_params),
    .in_writes_rd (in_writes_rd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_params   (out_params),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .flush        (flush),
    .busy_mask    (busy_mask),
    .stall_cnt    (stall_cnt)
  );

  task automatic drive(input logic v, input logic [4:0] a,
                       input logic [4:0] b, input logic [4:0] d,
                       input logic w, input logic [31:0] pc);
    in_valid     = v;
    in_params    = '{rs1: a, rs2: b, rd: d};
    in_writes_rd = w;
    in_instr     = '{pc: pc, insn: ~pc, op: OP_ALU};
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; wb_valid = 1'b0; wb_rd = '0;
    out_ready = 1'b1;
    drive(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 32'h100);
    #2;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL rst_in_ready got %0h exp 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL rst_out_valid got %0h exp 0", out_valid); end
    n_checks++;
    if (busy_mask !== 32'h0 || stall_cnt !== 16'h0) begin n_fail++;
      $display("FAIL rst_state got busy=%h stall=%h exp 0 0",
               busy_mask, stall_cnt); end
    n_checks++;
    if (out_params !== '0 || out_instr !== '0) begin n_fail++;
      $display("FAIL rst_out_data got %h %h exp 0 0",
               out_params, out_instr); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_params.rs1 !== 5'd3) begin n_fail++;
      $display("FAIL rst_first_latch got v=%0h rs1=%0d exp 1 3",
               out_valid, out_params.rs1); end
    in_valid = 1'b0;
  endtask

  task automatic test_raw_stall;
    @(negedge clk);
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 32'h200);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL raw_writer_ready got %0h exp 1", in_ready); end
    @(negedge clk);
    n_checks++;
    if (busy_mask !== 32'h20) begin n_fail++;
      $display("FAIL raw_busy_set got %h exp 00000020", busy_mask); end
    drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 32'h204);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++;
      $display("FAIL raw_stall_ready got %0h exp 0", in_ready); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (stall_cnt !== 16'd3) begin n_fail++;
      $display("FAIL raw_stall_cnt got %0d exp 3", stall_cnt); end
    wb_valid = 1'b1; wb_rd = 5'd5;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++;
      $display("FAIL raw_no_bypass got %0h exp 0", in_ready); end
    @(negedge clk);
    wb_valid = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || busy_mask !== 32'h0 || stall_cnt !== 16'd4)
    begin n_fail++;
      $display("FAIL raw_after_wb got rdy=%0h busy=%h st=%0d exp 1 0 4",
               in_ready, busy_mask, stall_cnt); end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_params.rs1 !== 5'd5) begin n_fail++;
      $display("FAIL raw_reader_issued got v=%0h rs1=%0d exp 1 5",
               out_valid, out_params.rs1); end
    in_valid = 1'b0;
  endtask

  task automatic test_x0;
    for (int k = 1; k < 32; k++) begin
      @(negedge clk);
      drive(1'b1, 5'd0, 5'd0, 5'(k), 1'b1, 32'h300 + 32'(k));
    end
    @(negedge clk);
    n_checks++;
    if (busy_mask !== 32'hFFFF_FFFE) begin n_fail++;
      $display("FAIL x0_all_busy got %h exp fffffffe", busy_mask); end
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 32'h400);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL x0_reader_ready got %0h exp 1", in_ready); end
    @(negedge clk);
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 32'h404);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL x0_writer_ready got %0h exp 1", in_ready); end
    @(negedge clk);
    n_checks++;
    if (busy_mask !== 32'hFFFF_FFFE || out_instr.pc !== 32'h404)
    begin n_fail++;
      $display("FAIL x0_write got busy=%h pc=%h exp fffffffe 404",
               busy_mask, out_instr.pc); end
    drive(1'b1, 5'd0, 5'd12, 5'd0, 1'b0, 32'h408);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++;
      $display("FAIL x0_rs2_hazard got %0h exp 0", in_ready); end
    in_valid = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      wb_valid = 1'b1; wb_rd = 5'(k);
    end
    @(negedge clk);
    wb_valid = 1'b0;
    n_checks++;
    if (busy_mask !== 32'h0) begin n_fail++;
      $display("FAIL x0_all_cleared got %h exp 0", busy_mask); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 32'hA000);
    @(negedge clk);
    drive(1'b1, 5'd3, 5'd4, 5'd0, 1'b0, 32'hB000);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_instr.pc !== 32'hA000 ||
          in_ready !== 1'b0) begin n_fail++;
        $display("FAIL hold_%0d got v=%0h pc=%h rdy=%0h exp 1 a000 0",
                 i, out_valid, out_instr.pc, in_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL b2b_ready got %0h exp 1", in_ready); end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_instr.pc !== 32'hB000 ||
        stall_cnt !== 16'd4) begin n_fail++;
      $display("FAIL b2b_accept got v=%0h pc=%h st=%0d exp 1 b000 4",
               out_valid, out_instr.pc, stall_cnt); end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_instr.pc !== 32'hB000) begin n_fail++;
      $display("FAIL drain got v=%0h pc=%h exp 0 b000",
               out_valid, out_instr.pc); end
  endtask

  task automatic test_flush_setwins;
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 32'hC000);
    @(negedge clk);
    n_checks++;
    if (busy_mask !== 32'h80 || out_valid !== 1'b1) begin n_fail++;
      $display("FAIL flush_pre got busy=%h v=%0h exp 00000080 1",
               busy_mask, out_valid); end
    flush = 1'b1;
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 32'hD000);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++;
      $display("FAIL flush_blocks got %0h exp 0", in_ready); end
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy_mask !== 32'h0) begin n_fail++;
      $display("FAIL flush_post got v=%0h busy=%h exp 0 0",
               out_valid, busy_mask); end
    wb_valid = 1'b1; wb_rd = 5'd9; out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL setwins_ready got %0h exp 1", in_ready); end
    @(negedge clk);
    n_checks++;
    if (busy_mask !== 32'h200 || out_params.rd !== 5'd9 ||
        out_instr.pc !== 32'hD000) begin n_fail++;
      $display("FAIL set_wins got busy=%h rd=%0d pc=%h exp 200 9 d000",
               busy_mask, out_params.rd, out_instr.pc); end
    in_valid = 1'b0;
    @(negedge clk);
    wb_valid = 1'b0;
    n_checks++;
    if (busy_mask !== 32'h0) begin n_fail++;
      $display("FAIL setwins_clear got %h exp 0", busy_mask); end
  endtask

  task automatic test_stall_sat;
    @(negedge clk);
    drive(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 32'hE000);
    @(negedge clk);
    drive(1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 32'hE004);
    repeat (65539) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (stall_cnt !== 16'hFFFF || busy_mask !== 32'h10) begin n_fail++;
      $display("FAIL stall_sat got st=%h busy=%h exp ffff 00000010",
               stall_cnt, busy_mask); end
  endtask

  task automatic test_async_reset;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || busy_mask !== 32'h0 ||
        stall_cnt !== 16'h0 || out_instr !== '0 || out_params !== '0)
    begin n_fail++;
      $display("FAIL async_rst got v=%0h busy=%h st=%h exp all 0",
               out_valid, busy_mask, stall_cnt); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL async_rst_ready got %0h exp 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_raw_stall();
    test_x0();
    test_back_to_back();
    test_flush_setwins();
    test_stall_sat();
    test_async_reset();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Registered issue stage directly downstream of register-file decode.
- Accepts a decoded instr_packet plus its reg_file_read_params_t (rs1, rs2, rd), tracks pending register writes in a scoreboard, and stalls on RAW/WAW hazards.
- Presents one instruction per cycle to execute over a valid/ready handshake.
- Writeback clears scoreboard entries; flush drops the held instruction.

Parameters:
- NUM_REGS, 32, architectural integer registers; index 0 is hard-wired x0.
- STALL_CNT_W, 16, width of the saturating hazard-stall counter.

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  decode holds a valid instruction
- in_ready  output  1  stage accepts the input this cycle
- in_instr  input  instr_packet  decoded instruction
- in_params  input  reg_file_read_params_t  rs1/rs2/rd (5 bits each)
- in_writes_rd  input  1  instruction writes rd
- out_valid  output  1  held instruction valid
- out_ready  input  1  execute consumes the held instruction
- out_instr  output  instr_packet  held instruction
- out_params  output  reg_file_read_params_t  held register params
- wb_valid  input  1  writeback retires a register write
- wb_rd  input  5  register being written back
- flush  input  1  discard the held instruction and block accept this cycle
- busy_mask  output  NUM_REGS  scoreboard state, bit 0 always 0
- stall_cnt  output  STALL_CNT_W  cycles with in_valid=1 and in_ready=0 due to a hazard

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: out_valid=0, out_instr=0, out_params=0, busy_mask=0, stall_cnt=0. Deassertion is synchronous to clk.
- Hazard: asserted when in_valid is high and any of the following is busy in the registered scoreboard:
  - busy[rs1] with rs1≠0
  - busy[rs2] with rs2≠0
  - busy[rd] with in_writes_rd=1 and rd≠0 (WAW)
- No same-cycle writeback bypass. A register cleared by wb in cycle N is usable for accept in cycle N+1.
- in_ready = ~hazard & ~flush & (~out_valid | out_ready). This path is combinational and must not depend on in_valid, except through the hazard term.
- Accept (in_valid & in_ready): on the next edge, out_* ← in_*, out_valid=1, busy[rd]←1 if in_writes_rd and rd≠0. Latency is 1 cycle.
- Drain: out_valid & out_ready & ~accept → out_valid=0 next edge. Held data is don't-care but must not change.
- Holding: out_valid & ~out_ready → out_instr/out_params stable.
- Scoreboard clear: wb_valid & wb_rd≠0 → busy[wb_rd]←0.
- Simultaneous set and clear of the same index: set wins, because the new writer is younger.
- Flush: out_valid←0 next edge. If the held instruction set its busy bit, that bit clears, unless wb also targets it in the same cycle (result is 0 either way). Bits of instructions already past this stage are untouched. Flush outranks out_ready. No accept occurs in a flush cycle.
- x0 handling: writes to x0 never set busy. wb_rd=0 is ignored.
- stall_cnt: increments when in_valid & hazard & ~flush, and saturates at all-ones.
- Reset mid-operation: all state returns to reset values immediately, and any pending writeback is lost.

Decomposition:
- Package issue_pkg:
  - scoreboard_t (logic [NUM_REGS-1:0])
  - REG_ADDR_W = 5
  - REGISTER_X0 constant shared with decode
- Sub-module reg_scoreboard:
  - inputs: set_en/set_idx, clr_en/clr_idx, flush_clr_en/flush_clr_idx
  - outputs: busy vector
  - rule: set-wins priority
- The top level holds the pipeline register, the hazard compare and the stall counter.

Test Plan:
- Reset with in_valid=1, rs1=3 → in_ready=1 and out_valid=0 during rst. First post-reset edge latches; out_params.rs1=3 one cycle later.
- Accept writer rd=5, then a reader with rs1=5 → in_ready=0, stall_cnt increments each cycle. wb_valid with wb_rd=5 in cycle N → in_ready=1 in cycle N+1; busy_mask[5]=0.
- Reader with rs1=0 and rs2=0 while busy_mask=all-ones except bit 0 → no hazard, accepted. Writer with rd=0 → busy_mask unchanged.
- out_ready=0 for 4 cycles while out_valid=1 → out_instr stable, in_ready=0. out_ready=1 with a new input → back-to-back accept, out_valid remains 1.
- Held writer rd=7 plus flush → out_valid=0 next cycle, busy_mask[7]=0, no accept that cycle. Same-cycle accept of rd=9 while wb_rd=9 → busy_mask[9]=1 (set wins).
- Hold a hazard for 2^STALL_CNT_W+3 cycles → stall_cnt saturates at all-ones. Assert rst asynchronously mid-cycle → all outputs 0 before the next edge.
